// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - opcode and FSM state types for the LCD window controller
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE   = 4'd0,
    CMD_UP      = 4'd1,
    CMD_DOWN    = 4'd2,
    CMD_LEFT    = 4'd3,
    CMD_RIGHT   = 4'd4,
    CMD_MAX     = 4'd5,
    CMD_MIN     = 4'd6,
    CMD_AVG     = 4'd7,
    CMD_ROT_CCW = 4'd8,
    CMD_ROT_CW  = 4'd9,
    CMD_MIR_H   = 4'd10,
    CMD_MIR_V   = 4'd11,
    CMD_RSV_12  = 4'd12,
    CMD_RSV_13  = 4'd13,
    CMD_RSV_14  = 4'd14,
    CMD_RSV_15  = 4'd15
  } cmd_e;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// rtl/lcd_win_alu.sv - combinational max/min/floor-average over a WIN x WIN window
module lcd_win_alu #(
  parameter int PIX_W = 8,
  parameter int WIN   = 4
) (
  input  logic [WIN*WIN*PIX_W-1:0] win_i,
  output logic [PIX_W-1:0]         max_o,
  output logic [PIX_W-1:0]         min_o,
  output logic [PIX_W-1:0]         avg_o
);

  localparam int NP = WIN * WIN;
  localparam int LW = $clog2(WIN);
  localparam int SW = PIX_W + 2 * LW;

  logic [SW-1:0] sum;

  always_comb begin
    max_o = win_i[PIX_W-1:0];
    min_o = win_i[PIX_W-1:0];
    sum   = '0;
    for (int i = 0; i < NP; i++) begin
      if (win_i[i*PIX_W +: PIX_W] > max_o) max_o = win_i[i*PIX_W +: PIX_W];
      if (win_i[i*PIX_W +: PIX_W] < min_o) min_o = win_i[i*PIX_W +: PIX_W];
      sum = sum + SW'(win_i[i*PIX_W +: PIX_W]);
    end
    // WIN^2 is a power of two, so the floor divide is a plain shift
    avg_o = PIX_W'(sum >> (2 * LW));
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// rtl/lcd_ctrl_param.sv - parametrised LCD image-window controller: load, window ops, write-back
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8,
  parameter int WIN   = 4,
  parameter int A_W   = $clog2(IMG_W * IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  input  logic [PIX_W-1:0] IROM_Q,
  output logic             IROM_rd,
  output logic [A_W-1:0]   IROM_A,
  output logic             IRAM_valid,
  output logic [PIX_W-1:0] IRAM_D,
  output logic [A_W-1:0]   IRAM_A,
  output logic             busy,
  output logic             done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int NW = WIN * WIN;
  localparam int HW = WIN / 2;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [A_W-1:0] LAST  = A_W'(N - 1);
  localparam logic [XW-1:0]  X_MIN = XW'(HW);
  localparam logic [XW-1:0]  X_MAX = XW'(IMG_W - HW);
  localparam logic [YW-1:0]  Y_MIN = YW'(HW);
  localparam logic [YW-1:0]  Y_MAX = YW'(IMG_H - HW);

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [A_W-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [PIX_W-1:0] pix_q [N];
  logic [PIX_W-1:0] pix_d [N];

  logic [A_W-1:0]      win_addr [NW];
  logic [PIX_W-1:0]    win      [NW];
  logic [PIX_W-1:0]    new_win  [NW];
  logic [NW*PIX_W-1:0] win_flat;
  logic [PIX_W-1:0]    win_max, win_min, win_avg;

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_addr[r*WIN+c] = A_W'((int'(y_q) - HW + r) * IMG_W + int'(x_q) - HW + c);
      end
    end
    for (int i = 0; i < NW; i++) begin
      win[i]                     = pix_q[win_addr[i]];
      win_flat[i*PIX_W +: PIX_W] = pix_q[win_addr[i]];
    end
  end

  lcd_win_alu #(
    .PIX_W (PIX_W),
    .WIN   (WIN)
  ) u_win_alu (
    .win_i (win_flat),
    .max_o (win_max),
    .min_o (win_min),
    .avg_o (win_avg)
  );

  // Window index is r*WIN+c; each op picks the source cell for destination (r,c)
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        case (cmd_q)
          CMD_MAX:     new_win[r*WIN+c] = win_max;
          CMD_MIN:     new_win[r*WIN+c] = win_min;
          CMD_AVG:     new_win[r*WIN+c] = win_avg;
          CMD_ROT_CCW: new_win[r*WIN+c] = win[c*WIN + (WIN-1-r)];
          CMD_ROT_CW:  new_win[r*WIN+c] = win[(WIN-1-c)*WIN + r];
          CMD_MIR_H:   new_win[r*WIN+c] = win[(WIN-1-r)*WIN + c];
          CMD_MIR_V:   new_win[r*WIN+c] = win[r*WIN + (WIN-1-c)];
          default:     new_win[r*WIN+c] = win[r*WIN+c];
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    case (state_q)
      ST_LOAD: begin
        pix_d[cnt_q] = IROM_Q;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd_e'(cmd);
          state_d = (cmd_e'(cmd) == CMD_WRITE) ? ST_WRITE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (cmd_q)
          CMD_UP:    if (y_q > Y_MIN) y_d = y_q - 1'b1;
          CMD_DOWN:  if (y_q < Y_MAX) y_d = y_q + 1'b1;
          CMD_LEFT:  if (x_q > X_MIN) x_d = x_q - 1'b1;
          CMD_RIGHT: if (x_q < X_MAX) x_d = x_q + 1'b1;
          // reserved opcodes fall through here with new_win == win
          default: begin
            for (int i = 0; i < NW; i++) pix_d[win_addr[i]] = new_win[i];
          end
        endcase
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      cmd_q   <= CMD_WRITE;
      cnt_q   <= '0;
      x_q     <= XW'(IMG_W / 2);
      y_q     <= YW'(IMG_H / 2);
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // The image is always reloaded after reset, so the array itself needs no reset
  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

  assign IROM_rd    = reset && (state_q == ST_LOAD);
  assign IROM_A     = (state_q == ST_LOAD) ? cnt_q : '0;
  assign IRAM_valid = (state_q == ST_WRITE);
  assign IRAM_A     = IRAM_valid ? cnt_q : '0;
  assign IRAM_D     = IRAM_valid ? pix_q[cnt_q] : '0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb/tb_lcd_ctrl_param.sv - directed self-checking bench for lcd_ctrl_param (8x8, WIN=4)
module tb_lcd_ctrl_param;

  localparam int IW = 8;
  localparam int IH = 8;
  localparam int PW = 8;
  localparam int WN = 4;
  localparam int AW = 6;
  localparam int N  = IW * IH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic [PW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [PW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  logic [PW-1:0] rom [N];
  logic [PW-1:0] ram [N];
  int            exp_img [N];
  int            checks = 0;
  int            failures = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;

  always #5 clk = ~clk;

  assign IROM_Q = rom[IROM_A];

  lcd_ctrl_param #(
    .IMG_W (IW),
    .IMG_H (IH),
    .PIX_W (PW),
    .WIN   (WN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_Q     (IROM_Q),
    .IROM_rd    (IROM_rd),
    .IROM_A     (IROM_A),
    .IRAM_valid (IRAM_valid),
    .IRAM_D     (IRAM_D),
    .IRAM_A     (IRAM_A),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) begin
    if (IRAM_valid) begin
      ram[IRAM_A] = IRAM_D;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    wait_idle("load_timeout", 100);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_idle("cmd_timeout", 200);
  endtask

  task automatic set_orig();
    for (int k = 0; k < N; k++) exp_img[k] = k;
  endtask

  task automatic fill_win(input int x0, input int y0, input int v);
    for (int r = 0; r < WN; r++)
      for (int c = 0; c < WN; c++)
        exp_img[(y0 + r) * IW + x0 + c] = v;
  endtask

  task automatic write_check(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < N; k++) ram[k] = 'x;
    wr_cnt = 0;
    done_cnt = 0;
    send_cmd(4'd0);
    chk({tag, "_wr_cnt"}, wr_cnt, N);
    chk({tag, "_done"}, done_cnt, 1);
    for (int k = 0; k < N; k++)
      if (ram[k] !== PW'(exp_img[k])) bad++;
    chk({tag, "_bad_pix"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int n;
    for (int k = 0; k < N; k++) rom[k] = PW'(k);

    // reset values and load sequence
    repeat (3) tick();
    chk("rst_irom_rd", IROM_rd, 0);
    chk("rst_irom_a", IROM_A, 0);
    chk("rst_iram_valid", IRAM_valid, 0);
    chk("rst_iram_d", IRAM_D, 0);
    chk("rst_iram_a", IRAM_A, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    reset = 1'b1;
    #1;
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (!(IROM_rd === 1'b1 && IROM_A === AW'(k) && busy === 1'b1)) bad++;
      tick();
    end
    chk("load_seq_bad_cycles", bad, 0);
    chk("load_rd_off", IROM_rd, 0);
    chk("load_busy_off", busy, 0);
    set_orig();
    write_check("orig");

    send_cmd(4'd5);
    set_orig(); fill_win(2, 2, 45);
    write_check("max");

    do_reset();
    send_cmd(4'd6);
    set_orig(); fill_win(2, 2, 18);
    write_check("min");

    do_reset();
    send_cmd(4'd7);
    set_orig(); fill_win(2, 2, 31);
    write_check("avg");

    do_reset();
    repeat (3) send_cmd(4'd3);
    send_cmd(4'd5);
    set_orig(); fill_win(0, 2, 43);
    write_check("left_max");

    do_reset();
    repeat (3) send_cmd(4'd1);
    send_cmd(4'd6);
    set_orig(); fill_win(2, 0, 2);
    write_check("up_min");

    do_reset();
    repeat (3) send_cmd(4'd4);
    repeat (3) send_cmd(4'd2);
    send_cmd(4'd5);
    set_orig(); fill_win(4, 4, 63);
    write_check("rd_max");

    // rotations and mirrors around the default point (window rows/cols 2..5)
    do_reset();
    send_cmd(4'd9);
    set_orig();
    for (int r = 0; r < WN; r++)
      for (int c = 0; c < WN; c++)
        exp_img[(2 + r) * IW + 2 + c] = (5 - c) * IW + 2 + r;
    write_check("rot_cw");
    send_cmd(4'd8);
    set_orig();
    write_check("rot_back");
    send_cmd(4'd10);
    for (int r = 0; r < WN; r++)
      for (int c = 0; c < WN; c++)
        exp_img[(2 + r) * IW + 2 + c] = (5 - r) * IW + 2 + c;
    write_check("mir_h");
    send_cmd(4'd10);
    set_orig();
    write_check("mir_h_back");
    send_cmd(4'd11);
    for (int r = 0; r < WN; r++)
      for (int c = 0; c < WN; c++)
        exp_img[(2 + r) * IW + 2 + c] = (2 + r) * IW + 5 - c;
    write_check("mir_v");

    // reserved opcode, with a command offered while busy
    cmd = 4'd13;
    cmd_valid = 1'b1;
    tick();
    chk("rsv_busy", busy, 1);
    cmd = 4'd5;
    tick();
    cmd_valid = 1'b0;
    chk("rsv_busy_one_cycle", busy, 0);
    tick();
    chk("busy_cmd_ignored", busy, 0);
    write_check("rsv_nochange");

    // reset in the middle of a write
    cmd = 4'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(IRAM_valid && IRAM_A == AW'(20)) && n < 100) begin
      tick();
      n++;
    end
    chk("mid_wr_reach_a20", IRAM_A, 20);
    reset = 1'b0;
    #1;
    chk("mid_rst_iram_valid", IRAM_valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_irom_rd", IROM_rd, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("reload_rd", IROM_rd, 1);
    chk("reload_a0", IROM_A, 0);
    wait_idle("reload_timeout", 100);
    set_orig();
    write_check("reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
